serial_adder: RTL

Bit-serial N-bit adder built around a single one-bit full-adder cell and a carry flip-flop. It accepts two parallel operands on a start strobe and processes one bit per clock, LSB first. It then presents the parallel sum and carry-out with a one-cycle done pulse. It sits between operand-producing logic and any consumer that can trade latency for area versus a ripple-carry adder.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/serial_adder_if.sv | 33 +++
 rtl/serial_adder_fa_bit.sv | 11 +
 rtl/serial_adder.sv | 109 ++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  // The counter must be able to hold WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder.
// SERIAL_ADDER_SUB_EN adds the sub select signal.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_fa_bit.sv
// One-bit full-adder cell used once per clock by serial_adder.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ c;
  assign cout = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder step per clock.
// SERIAL_ADDER_SUB_EN enables a - b via the interface sub signal.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_adder_if.slave      bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             fa_s;
  logic             fa_c;

  always_comb begin
    b_load = bus.b;
    c_load = bus.cin;
`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: invert b and inject a carry of one.
    if (bus.sub) begin
      b_load = ~bus.b;
      c_load = 1'b1;
    end
`endif
  end

  fa_bit u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .c    (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  // The shifting sum register is separate from the presented sum so a result
  // stays stable until the next one completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      s_sr   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sr   <= bus.a;
            b_sr   <= b_load;
            carry  <= c_load;
            cnt    <= '0;
            state  <= S_RUN;
            busy_q <= 1'b1;
          end else begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
        S_RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          s_sr  <= {fa_s, s_sr[WIDTH-1:1]};
          carry <= fa_c;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            sum_q  <= {fa_s, s_sr[WIDTH-1:1]};
            cout_q <= fa_c;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
